// File: rtl/mrr_lock_bank.sv
// ---------------------------------------------------------------------------
// mrr_lock_bank: multi-ring thermal wavelength lock (sweep, then hill-climb).
// Optional MRR_LOCK_STATS_EN builds per-channel relock counters.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mrr_lock_bank #(
  parameter int                NUM_CH      = 8,
  parameter int                PWR_W       = 16,
  parameter int                HEATER_W    = 12,
  parameter int                SWEEP_STEP  = 4,
  parameter logic [PWR_W-1:0]  LOCK_THRESH = 16'h4000,
  parameter int                LOSS_COUNT  = 4,
  parameter int                CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       enable,
  input  logic                       sample_valid,
  output logic                       sample_ready,
  input  logic [CH_W-1:0]            sample_ch,
  input  logic [PWR_W-1:0]           sample_power,
  output logic [NUM_CH*HEATER_W-1:0] heater_code,
  output logic [NUM_CH-1:0]          lock_status,
  output logic [NUM_CH-1:0]          sweep_fail,
  output logic [NUM_CH*8-1:0]        relock_count
);

  localparam int                MISS_W    = $clog2(LOSS_COUNT + 1);
  localparam logic [CH_W:0]     NUM_CH_V  = NUM_CH[CH_W:0];
  localparam logic [HEATER_W:0] HMAX      = {1'b0, {HEATER_W{1'b1}}};
  localparam logic [HEATER_W:0] STEP_C    = SWEEP_STEP[HEATER_W:0];
  localparam logic [MISS_W-1:0] MISS_LAST = MISS_W'(LOSS_COUNT - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWEEP = 2'd1,
    ST_TRACK = 2'd2
  } state_e;

  state_e              state_q  [NUM_CH];
  logic [HEATER_W-1:0] heater_q [NUM_CH];
  logic [PWR_W-1:0]    last_q   [NUM_CH];
  logic                dir_q    [NUM_CH];   // 1 = heater stepping up
  logic [MISS_W-1:0]   miss_q   [NUM_CH];
  logic [NUM_CH-1:0]   lock_q;
  logic [NUM_CH-1:0]   fail_q;

  logic                pend_q;
  logic [CH_W-1:0]     pch_q;
  logic [PWR_W-1:0]    ppwr_q;

  logic                w_hit;
  logic [CH_W-1:0]     w_idx;
  state_e              cur_st;
  logic [HEATER_W-1:0] cur_h;
  logic                dir_t;
  logic [HEATER_W:0]   w_sum;
  logic [HEATER_W:0]   w_inc;

  state_e              st_d;
  logic [HEATER_W-1:0] heater_d;
  logic [PWR_W-1:0]    last_d;
  logic                dir_d;
  logic [MISS_W-1:0]   miss_d;
  logic                fail_set_d;

  assign sample_ready = enable && !pend_q;

  // Out-of-range tags are accepted but must never touch channel state.
  assign w_hit = ({1'b0, pch_q} < NUM_CH_V);
  assign w_idx = w_hit ? pch_q : '0;

  assign cur_st = state_q[w_idx];
  assign cur_h  = heater_q[w_idx];
  assign w_sum  = {1'b0, cur_h} + STEP_C;
  assign w_inc  = {1'b0, cur_h} + (HEATER_W + 1)'(1);
  assign dir_t  = (ppwr_q < last_q[w_idx]) ? ~dir_q[w_idx] : dir_q[w_idx];

  always_comb begin
    st_d       = cur_st;
    heater_d   = cur_h;
    last_d     = last_q[w_idx];
    dir_d      = dir_q[w_idx];
    miss_d     = miss_q[w_idx];
    fail_set_d = 1'b0;
    case (cur_st)
      ST_TRACK: begin
        last_d = ppwr_q;
        if (dir_t) begin
          if (w_inc > HMAX) begin
            dir_d = 1'b0;
          end else begin
            heater_d = w_inc[HEATER_W-1:0];
            dir_d    = 1'b1;
          end
        end else begin
          if (cur_h == '0) begin
            dir_d = 1'b1;
          end else begin
            heater_d = cur_h - HEATER_W'(1);
            dir_d    = 1'b0;
          end
        end
        if (ppwr_q < LOCK_THRESH) begin
          if (miss_q[w_idx] == MISS_LAST) begin
            st_d   = ST_SWEEP;
            miss_d = '0;
          end else begin
            miss_d = miss_q[w_idx] + MISS_W'(1);
          end
        end else begin
          miss_d = '0;
        end
      end
      default: begin
        // IDLE treats its first sample exactly like a SWEEP sample.
        if (ppwr_q >= LOCK_THRESH) begin
          st_d   = ST_TRACK;
          last_d = ppwr_q;
          dir_d  = 1'b1;
          miss_d = '0;
        end else begin
          st_d = ST_SWEEP;
          if (w_sum > HMAX) begin
            heater_d   = '0;
            fail_set_d = 1'b1;
          end else begin
            heater_d = w_sum[HEATER_W-1:0];
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend_q <= 1'b0;
      pch_q  <= '0;
      ppwr_q <= '0;
      lock_q <= '0;
      fail_q <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i]  <= ST_IDLE;
        heater_q[i] <= '0;
        last_q[i]   <= '0;
        dir_q[i]    <= 1'b1;
        miss_q[i]   <= '0;
      end
    end else if (!enable) begin
      // Heater codes are deliberately held so rings stay near their last point.
      pend_q <= 1'b0;
      lock_q <= '0;
      fail_q <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= ST_IDLE;
        miss_q[i]  <= '0;
      end
    end else if (pend_q) begin
      pend_q <= 1'b0;
      if (w_hit) begin
        state_q[w_idx]  <= st_d;
        heater_q[w_idx] <= heater_d;
        last_q[w_idx]   <= last_d;
        dir_q[w_idx]    <= dir_d;
        miss_q[w_idx]   <= miss_d;
        lock_q[w_idx]   <= (st_d == ST_TRACK);
        if (fail_set_d) begin
          fail_q[w_idx] <= 1'b1;
        end
      end
    end else if (sample_valid) begin
      pend_q <= 1'b1;
      pch_q  <= sample_ch;
      ppwr_q <= sample_power;
    end
  end

  assign lock_status = lock_q;
  assign sweep_fail  = fail_q;

`ifdef MRR_LOCK_STATS_EN
  logic [7:0] relock_q [NUM_CH];
  logic       w_relock;

  assign w_relock = enable && pend_q && w_hit &&
                    (cur_st == ST_TRACK) && (st_d == ST_SWEEP);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        relock_q[i] <= '0;
      end
    end else if (w_relock && (relock_q[w_idx] != 8'hFF)) begin
      relock_q[w_idx] <= relock_q[w_idx] + 8'd1;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_relock
    assign relock_count[i*8 +: 8] = relock_q[i];
  end
`else
  assign relock_count = '0;
`endif

  for (genvar i = 0; i < NUM_CH; i++) begin : g_heater
    assign heater_code[i*HEATER_W +: HEATER_W] = heater_q[i];
  end

endmodule

`default_nettype wire
